combo_lock_fsm: RTL and testbench

COMBO_LOCK_FSM -- requirements
Module: combo_lock_fsm

---
 rtl/combo_lock_fsm.sv | 133 +++++++++++++
 tb/tb_combo_lock_fsm.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_fsm.sv
// Keypad combination lock: debounced press edges feed an IDLE/ENTRY/OPEN/LOCK FSM.
// Outputs are decoded from registered state; one shared timer serves OPEN and LOCK.
module combo_lock_fsm #(
  parameter int          CODE_LEN    = 5,
  parameter logic [31:0] CODE        = 32'h00052419,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCKOUT_CYC = 1000,
  parameter int          OPEN_CYC    = 500
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [9:0] K,
  input  logic       Dr,
  output logic       Z,
  output logic       Lockout,
  output logic [1:0] State,
  output logic [2:0] Digit_cnt,
  output logic [3:0] Fail_cnt
);

  localparam int MAX_CYC = (LOCKOUT_CYC > OPEN_CYC) ? LOCKOUT_CYC : OPEN_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    OPEN  = 2'd2,
    LOCK  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    digit_cnt, digit_n;
  logic [3:0]    fail_cnt, fail_n, fail_inc;
  logic          err, err_n, err_acc;
  logic [9:0]    k_q, k_prev;
  logic [1:0]    warm;

  logic          press, onehot, mismatch, last;
  logic [3:0]    digit, exp_digit;
  logic [2:0]    pos;
  logic [31:0]   code_sh;

  // warm blocks a press until k_prev holds a real sample, so a key held through reset is ignored
  assign press  = warm[1] && (|k_q) && !(|k_prev);
  assign onehot = $onehot(k_q);

  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (k_q[i]) digit = 4'(i);
    end
  end

  assign pos       = (state == IDLE) ? 3'd0 : digit_cnt;
  assign code_sh   = CODE >> (4 * (CODE_LEN - 1 - int'(pos)));
  assign exp_digit = code_sh[3:0];
  assign mismatch  = !onehot || (digit != exp_digit);
  assign err_acc   = ((state == IDLE) ? 1'b0 : err) | mismatch;
  assign last      = ({1'b0, pos} + 4'd1) == 4'(CODE_LEN);
  assign fail_inc  = (fail_cnt < 4'(MAX_FAIL)) ? fail_cnt + 4'd1 : fail_cnt;

  always_comb begin
    state_n = state;
    digit_n = digit_cnt;
    fail_n  = fail_cnt;
    err_n   = err;
    case (state)
      IDLE, ENTRY: begin
        if (press) begin
          err_n = err_acc;
          if (last) begin
            digit_n = 3'd0;
            if (!err_acc) begin
              state_n = OPEN;
              fail_n  = 4'd0;
            end else begin
              fail_n  = fail_inc;
              state_n = (fail_inc == 4'(MAX_FAIL)) ? LOCK : IDLE;
            end
          end else begin
            digit_n = pos + 3'd1;
            state_n = ENTRY;
          end
        end
      end
      OPEN: begin
        if (Dr || timer == TW'(OPEN_CYC - 1)) state_n = IDLE;
      end
      LOCK: begin
        if (timer == TW'(LOCKOUT_CYC - 1)) begin
          state_n = IDLE;
          fail_n  = 4'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    timer_n = '0;
    if (state_n == state && (state == OPEN || state == LOCK)) timer_n = timer + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      digit_cnt <= 3'd0;
      fail_cnt  <= 4'd0;
      err       <= 1'b0;
      k_q       <= 10'd0;
      k_prev    <= 10'd0;
      warm      <= 2'b00;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      digit_cnt <= digit_n;
      fail_cnt  <= fail_n;
      err       <= err_n;
      k_q       <= K;
      k_prev    <= k_q;
      warm      <= {warm[0], 1'b1};
    end
  end

  assign Z         = (state == OPEN);
  assign Lockout   = (state == LOCK);
  assign State     = state;
  assign Digit_cnt = digit_cnt;
  assign Fail_cnt  = fail_cnt;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Directed bench for combo_lock_fsm with default parameters (code 5-2-4-1-9).
module tb_combo_lock_fsm;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [9:0] K;
  logic       Dr;
  logic       Z, Lockout;
  logic [1:0] State;
  logic [2:0] Digit_cnt;
  logic [3:0] Fail_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt;

  always #5 Clk = ~Clk;

  combo_lock_fsm dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .K         (K),
    .Dr        (Dr),
    .Z         (Z),
    .Lockout   (Lockout),
    .State     (State),
    .Digit_cnt (Digit_cnt),
    .Fail_cnt  (Fail_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [9:0] m);
    K = m;
    repeat (2) @(negedge Clk);
    K = 10'd0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic dig(input int d);
    key(10'b1 << d);
  endtask

  initial begin
    Reset_n = 1'b0;
    K       = 10'd0;
    Dr      = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_state", 32'(State), 0);
    chk("rst_z", 32'(Z), 0);
    chk("rst_lockout", 32'(Lockout), 0);
    chk("rst_digit", 32'(Digit_cnt), 0);
    chk("rst_fail", 32'(Fail_cnt), 0);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);

    // correct code, then door opened
    dig(5);
    chk("ok_d1_state", 32'(State), 1);
    chk("ok_d1_cnt", 32'(Digit_cnt), 1);
    dig(2);
    chk("ok_d2_cnt", 32'(Digit_cnt), 2);
    dig(4);
    chk("ok_d3_cnt", 32'(Digit_cnt), 3);
    dig(1);
    chk("ok_d4_cnt", 32'(Digit_cnt), 4);
    chk("ok_d4_state", 32'(State), 1);
    K = 10'b1 << 9;
    @(negedge Clk);
    chk("ok_pre_state", 32'(State), 1);
    chk("ok_pre_z", 32'(Z), 0);
    @(negedge Clk);
    chk("ok_open_z", 32'(Z), 1);
    chk("ok_open_state", 32'(State), 2);
    chk("ok_open_cnt", 32'(Digit_cnt), 0);
    K = 10'd0;
    @(negedge Clk);
    Dr = 1'b1;
    @(negedge Clk);
    chk("dr_z", 32'(Z), 0);
    chk("dr_state", 32'(State), 0);
    Dr = 1'b0;
    @(negedge Clk);

    // wrong last digit, then wrong first digit
    dig(5); dig(2); dig(4); dig(1); dig(0);
    chk("bad1_z", 32'(Z), 0);
    chk("bad1_fail", 32'(Fail_cnt), 1);
    chk("bad1_state", 32'(State), 0);
    dig(0);
    chk("bad2_d1_state", 32'(State), 1);
    dig(2); dig(4); dig(1);
    chk("bad2_no_abort", 32'(Digit_cnt), 4);
    dig(9);
    chk("bad2_fail", 32'(Fail_cnt), 2);
    chk("bad2_state", 32'(State), 0);

    // third failure locks out; presses during lockout ignored
    dig(1); dig(1); dig(1); dig(1); dig(1);
    chk("lock_state", 32'(State), 3);
    chk("lock_out", 32'(Lockout), 1);
    chk("lock_fail", 32'(Fail_cnt), 3);
    cnt = 3;
    dig(5);
    chk("lock_ign_cnt", 32'(Digit_cnt), 0);
    chk("lock_ign_state", 32'(State), 3);
    dig(2);
    cnt += 8;
    @(negedge Clk);
    while (Lockout === 1'b1 && cnt < 1100) begin
      cnt++;
      @(negedge Clk);
    end
    chk("lock_len", 32'(cnt), 1000);
    chk("unlock_state", 32'(State), 0);
    chk("unlock_fail", 32'(Fail_cnt), 0);
    dig(5); dig(2); dig(4); dig(1); dig(9);
    chk("post_lock_z", 32'(Z), 1);
    Dr = 1'b1;
    @(negedge Clk);
    Dr = 1'b0;
    chk("post_lock_close", 32'(State), 0);
    @(negedge Clk);

    // door never opened: relock after OPEN_CYC cycles
    dig(5); dig(2); dig(4); dig(1);
    K = 10'b1 << 9;
    repeat (2) @(negedge Clk);
    K = 10'd0;
    cnt = 0;
    while (Z === 1'b1 && cnt < 600) begin
      cnt++;
      @(negedge Clk);
    end
    chk("open_len", 32'(cnt), 500);
    chk("relock_state", 32'(State), 0);
    chk("relock_z", 32'(Z), 0);

    // two keys together count as one invalid digit
    key((10'b1 << 5) | (10'b1 << 2));
    chk("multi_cnt", 32'(Digit_cnt), 1);
    dig(2); dig(4); dig(1); dig(9);
    chk("multi_fail", 32'(Fail_cnt), 1);
    chk("multi_z", 32'(Z), 0);
    chk("multi_state", 32'(State), 0);

    // held and rolled-over keys give a single event
    K = 10'b1 << 5;
    repeat (6) @(negedge Clk);
    chk("hold_cnt", 32'(Digit_cnt), 1);
    K = 10'b1 << 2;
    repeat (3) @(negedge Clk);
    chk("roll_cnt", 32'(Digit_cnt), 1);
    K = 10'd0;
    repeat (2) @(negedge Clk);
    dig(2);
    chk("roll_d2_cnt", 32'(Digit_cnt), 2);

    // asynchronous reset mid-entry, key held across reset
    Reset_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(Digit_cnt), 0);
    chk("arst_state", 32'(State), 0);
    chk("arst_fail", 32'(Fail_cnt), 0);
    @(negedge Clk);
    K = 10'b1 << 5;
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    chk("held_rst_cnt", 32'(Digit_cnt), 0);
    chk("held_rst_state", 32'(State), 0);
    K = 10'd0;
    repeat (2) @(negedge Clk);
    dig(5); dig(2); dig(4); dig(1); dig(9);
    chk("post_rst_z", 32'(Z), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
